fifo_rd_streamer: RTL and testbench

- Read-side consumer for the async FIFO (fifo_top) read port, clocked in the read domain.
- Issues rd_en against empty and captures rd_data, which the FIFO returns one rd_clk cycle after rd_en.
- Re-presents captured words as a valid/ready stream to downstream logic, at full throughput (one word per cycle) under continuous ready.
- Makes the FIFO's registered read latency invisible downstream.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_skid_buf.sv | 63 ++++++
 rtl/fifo_rd_streamer.sv | 82 ++++++++
 tb/tb_fifo_rd_streamer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO and its read-side streamer.
package fifo_pkg;

  localparam int FIFO_DATA_SIZE = 4;
  localparam int FIFO_ADDR_SIZE = 4;
  localparam int FIFO_BUF_DEPTH = 3;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int clog2_depth(input int depth);
    int w;
    w = 1;
    while ((32'sd1 << w) <= depth) w = w + 1;
    return w;
  endfunction

  localparam int FIFO_OCC_W = clog2_depth(FIFO_BUF_DEPTH);

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer sitting behind the FIFO read port.
// Pointers wrap by explicit compare so any depth from 2 to 8 works.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE,
  parameter int BUF_DEPTH = FIFO_BUF_DEPTH,
  parameter int OCC_W     = clog2_depth(BUF_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] head_data,
  output logic [OCC_W-1:0]     occ
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

  logic [DATA_SIZE-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic                 push_ok;
  logic                 pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Guard against pops when empty and pushes into a full buffer that is not draining.
  always_comb begin
    pop_ok  = pop && (occ != '0);
    push_ok = push && ((occ != OCC_FULL) || pop_ok);
  end

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[tail] <= push_data;
        tail      <= ptr_next(tail);
      end
      if (pop_ok) head <= ptr_next(head);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Head of buffer is a plain read of the registered array.
  always_comb head_data = mem[head];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side consumer of the async FIFO: issues rd_en on credit, captures
// the word returned one cycle later and re-presents it as a valid/ready
// stream. Optional statistics counters are enabled by FIFO_RD_STATS_EN.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE,
  parameter int BUF_DEPTH = FIFO_BUF_DEPTH
) (
  input  logic                               rd_clk,
  input  logic                               rd_rst,
  input  logic                               empty,
  input  logic [DATA_SIZE-1:0]               rd_data,
  output logic                               rd_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_SIZE-1:0]               out_data,
  output logic [clog2_depth(BUF_DEPTH)-1:0]  occupancy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]                        word_count,
  output logic [15:0]                        stall_count
`endif
);

  localparam int OCC_W = clog2_depth(BUF_DEPTH);
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(BUF_DEPTH);

  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic             pop;

  // Credit check: every outstanding read already owns a buffer slot, so
  // the buffer can never overflow. No path from out_ready by design.
  always_comb begin
    rd_en = !empty && !rd_rst &&
            (({1'b0, occ} + (OCC_W + 1)'(inflight)) < DEPTH_C);
  end

  // Stream-side handshake and status.
  always_comb begin
    out_valid = (occ != '0);
    pop       = out_valid && out_ready;
    occupancy = occ;
  end

  // A read issued this cycle returns data on the next one.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) inflight <= 1'b0;
    else        inflight <= rd_en;
  end

  fifo_rd_skid_buf #(
    .DATA_SIZE (DATA_SIZE),
    .BUF_DEPTH (BUF_DEPTH),
    .OCC_W     (OCC_W)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (pop),
    .head_data (out_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_STATS_EN
  // Saturating counters of delivered words and back-pressured cycles.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (word_count != 16'hFFFF))
        word_count <= word_count + 16'd1;
      if (out_valid && !out_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: the bench plays the FIFO (registered read),
// a scoreboard queue holds words in FIFO order and a monitor checks the stream.
module tb_fifo_rd_streamer;

  localparam int DW    = 4;
  localparam int DEPTH = 3;
  localparam int OW    = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occupancy;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   word_count;
  logic [15:0]   stall_count;
`endif

  fifo_rd_streamer #(.DATA_SIZE(DW), .BUF_DEPTH(DEPTH)) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .empty       (empty),
    .rd_data     (rd_data),
    .rd_en       (rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_count  (word_count),
    .stall_count (stall_count)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            reads_issued = 0;
  bit            last_taken   = 1'b0;
  int            pops         = 0;
  int            stat_pops    = 0;
  int            stat_stalls  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called in the posedge+1 phase only.
  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: drive ready, sample at negedge, then emulate the FIFO's
  // registered read response just after the edge.
  task automatic cycle(input bit rdy, output bit t, output bit v, output logic [DW-1:0] d);
    out_ready = rdy;
    @(negedge rd_clk);
    t = rd_en;
    v = out_valid;
    d = out_data;
    @(posedge rd_clk);
    #1;
    if (t && fifo_q.size() > 0) begin
      rd_data = fifo_q.pop_front();
      reads_issued++;
    end
    last_taken = t;
    empty = (fifo_q.size() == 0);
  endtask

  task automatic flush_model();
    fifo_q.delete();
    exp_q.delete();
    reads_issued = 0;
    last_taken   = 1'b0;
    empty        = 1'b1;
  endtask

  task automatic apply_reset(input int n);
    bit t, v; logic [DW-1:0] d;
    rd_rst = 1'b1;
    flush_model();
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, t, v, d);
      check("rst_rd_en", t, 0);
      check("rst_valid", v, 0);
      check("rst_occ", occupancy, 0);
    end
    #2 rd_rst = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    bit t, v; logic [DW-1:0] d;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cyc) begin
      cycle(1'b1, t, v, d);
      n++;
    end
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks invariants.
  initial begin : monitor
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            model_occ;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      if (rd_rst) begin
        pops        = 0;
        stat_pops   = 0;
        stat_stalls = 0;
        prev_stall  = 1'b0;
      end else begin
        model_occ = reads_issued - int'(last_taken) - pops;
        if (rd_en) check("rd_en_when_empty", empty, 0);
        check("occ_bound", int'(occupancy <= DEPTH), 1);
        check("occupancy", occupancy, model_occ);
        check("out_valid", out_valid, int'(model_occ != 0));
        if (prev_stall) check("hold_data", out_data, prev_data);
        if (out_valid && !out_ready) stat_stalls++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0d, expected none", out_data);
          end else begin
            check("data", out_data, exp_q.pop_front());
          end
          pops++;
          stat_pops++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin : stimulus
    bit            t, v;
    logic [DW-1:0] d;
    int            first_rd, n_rd, first_v, last_v, n_v, n;
    logic [DW-1:0] first_d;
    logic [DW-1:0] w3 [3];
    rd_rst    = 1'b1;
    empty     = 1'b1;
    rd_data   = '0;
    out_ready = 1'b0;
    @(posedge rd_clk);
    #1;
    apply_reset(5);

    // Three preloaded words, continuous ready.
    w3[0] = 4'b1010; w3[1] = 4'b1100; w3[2] = 4'b1111;
    for (int i = 0; i < 3; i++) push_word(w3[i]);
    first_rd = -1; n_rd = 0; first_v = -1; last_v = -1; n_v = 0; first_d = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, t, v, d);
      if (t) begin n_rd++; if (first_rd < 0) first_rd = i; end
      if (v) begin
        n_v++; last_v = i;
        if (first_v < 0) begin first_v = i; first_d = d; end
      end
    end
    check("t2_rd_pulses", n_rd, 3);
    check("t2_latency", first_v - first_rd, 2);
    check("t2_valid_cycles", n_v, 3);
    check("t2_valid_contig", last_v - first_v, 2);
    check("t2_first_word", first_d, 4'b1010);

    // Six words, downstream stalled: credit caps reads at BUF_DEPTH.
    for (int i = 0; i < 6; i++) push_word(DW'(i + 3));
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, t, v, d);
      if (t) n_rd++;
    end
    check("t3_rd_pulses", n_rd, 3);
    check("t3_occ_full", occupancy, DEPTH);
    check("t3_rd_en_off", rd_en, 0);
    check("t3_head", out_data, 3);
    first_v = -1; last_v = -1; n_v = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, t, v, d);
      if (v) begin n_v++; last_v = i; if (first_v < 0) first_v = i; end
    end
    check("t3_delivered", n_v, 6);
    check("t3_no_gaps", last_v - first_v, 5);

    // Ready toggling every cycle.
    for (int i = 0; i < 8; i++) push_word(DW'($urandom_range(0, 15)));
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      cycle(n[0] == 1'b0, t, v, d);
      n++;
    end
    check("t4_left", exp_q.size(), 0);

    // Five words with exactly two stall cycles.
    apply_reset(2);
    for (int i = 0; i < 5; i++) push_word(DW'(i + 8));
    n = 0;
    while (!out_valid && n < 10) begin cycle(1'b1, t, v, d); n++; end
    check("t5_valid_seen", out_valid, 1);
    cycle(1'b0, t, v, d);
    cycle(1'b0, t, v, d);
    drain("t5", 20);
`ifdef FIFO_RD_STATS_EN
    check("t5_word_count", word_count, 5);
    check("t5_stall_count", stall_count, 2);
`endif

    // Asynchronous reset with two buffered words and one read in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(4'b1110);
    n = 0;
    while (!(occupancy == 2 && last_taken) && n < 10) begin cycle(1'b0, t, v, d); n++; end
    check("t6_setup_occ", occupancy, 2);
    check("t6_setup_inflight", last_taken, 1);
    #2 rd_rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_rd_en", rd_en, 0);
    check("t6_rst_occ", occupancy, 0);
    flush_model();
    @(posedge rd_clk);
    #1;
    @(posedge rd_clk);
    #3 rd_rst = 1'b0;
    push_word(4'b0101);
    n = 0; first_v = 0; first_d = '0;
    while (first_v == 0 && n < 10) begin
      cycle(1'b1, t, v, d);
      if (v) begin first_v = 1; first_d = d; end
      n++;
    end
    check("t6_first_after_rst", first_d, 4'b0101);
    drain("t6", 10);

    // Randomized traffic with varying back-pressure bias.
    for (int i = 0; i < 1500; i++) begin
      if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0)
        push_word(DW'($urandom_range(0, 15)));
      cycle(($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 8 : 3)), t, v, d);
    end
    drain("rand", 80);
`ifdef FIFO_RD_STATS_EN
    check("word_count", word_count, stat_pops);
    check("stall_count", stall_count, stat_stalls);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
